fme_interp_stream: RTL

Parametrised, row-streaming successor to the fixed 32-in/162-out FME interpolator. It computes HEVC luma half-pel samples for a BLK_W x BLK_H block: horizontal (h), vertical (v) and, optionally, diagonal (d). Reference rows arrive one per handshake, are held in an 8-row sliding window, and the block emits one output row per accepted row once the window is full. It sits between the reference-fetch buffer and the FME cost/SAD stage.

---
 rtl/fme_pkg.sv | 14 +
 rtl/fme_filter8.sv | 30 +++
 rtl/fme_interp_stream.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fme_pkg.sv
// rtl/fme_pkg.sv - shared taps, intermediate widths, rounding constants and FSM state type for the FME interpolator
package fme_pkg;

  localparam int TAPS [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};

  localparam int H_SUM_W = 16;
  localparam int D_SUM_W = 24;

  localparam int RND6  = 32;
  localparam int RND12 = 2048;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

endpackage

// File: rtl/fme_filter8.sv
// rtl/fme_filter8.sv - combinational 8-tap signed dot product over the half-pel taps, unrounded
module fme_filter8
  import fme_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic [8*IN_W-1:0]       x,
  output logic signed [OUT_W-1:0] sum
);

  logic signed [IN_W-1:0]  xi;
  logic signed [OUT_W-1:0] xe;
  logic signed [OUT_W-1:0] acc;

  // Each tap input is treated as signed; callers zero-extend unsigned pixels.
  always_comb begin
    xi  = '0;
    xe  = '0;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      xi  = x[i*IN_W +: IN_W];
      xe  = OUT_W'(xi);
      acc = acc + xe * OUT_W'(TAPS[i]);
    end
  end

  assign sum = acc;

endmodule

// File: rtl/fme_interp_stream.sv
// rtl/fme_interp_stream.sv - row-streaming HEVC luma half-pel interpolator (h, v; diagonal d when FME_DIAG_EN is defined)
module fme_interp_stream
  import fme_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BLK_W      = 8,
  parameter int BLK_H      = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [(BLK_W+7)*DATA_WIDTH-1:0] in_row,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BLK_W*DATA_WIDTH-1:0]     out_h,
  output logic [BLK_W*DATA_WIDTH-1:0]     out_v,
  output logic [BLK_W*DATA_WIDTH-1:0]     out_d,
  output logic                            out_valid,
  output logic [$clog2(BLK_H)-1:0]        out_row,
  output logic                            done
);

  localparam int ROW_W = (BLK_W+7)*DATA_WIDTH;
  localparam int OUT_W = BLK_W*DATA_WIDTH;
  localparam int SX_W  = DATA_WIDTH+1;
  localparam int CNT_W = $clog2(BLK_H+8);
  localparam int IDX_W = $clog2(BLK_H);
  localparam logic signed [31:0] MAX_PIX = (32'sd1 <<< DATA_WIDTH) - 32'sd1;
`ifdef FME_DIAG_EN
  localparam int HR_LO = 0;
  localparam int HR_HI = 7;
`else
  localparam int HR_LO = 3;
  localparam int HR_HI = 3;
`endif

  state_t                    state;
  logic [ROW_W-1:0]          hist [7];
  logic [ROW_W-1:0]          nwin [8];
  logic [CNT_W-1:0]          rows_cnt;
  logic                      accept;
  logic                      emit;
  logic [OUT_W-1:0]          h_res;
  logic [OUT_W-1:0]          v_res;
  logic signed [H_SUM_W-1:0] hs [HR_LO:HR_HI][BLK_W];
  logic signed [H_SUM_W-1:0] vs [BLK_W];

  function automatic logic [DATA_WIDTH-1:0] round_clip(input logic signed [31:0] s,
                                                       input int sh,
                                                       input logic signed [31:0] rnd);
    logic signed [31:0] t;
    t = (s + rnd) >>> sh;
    if (t < 0) return '0;
    if (t > MAX_PIX) return '1;
    return t[DATA_WIDTH-1:0];
  endfunction

  assign accept = in_ready && in_valid;
  assign emit   = accept && (rows_cnt >= CNT_W'(7));

  // The 8-row window seen by the filters is the 7 stored rows plus the row being
  // accepted, so a result is registered on the same edge that takes its last row.
  always_comb begin
    for (int i = 0; i < 7; i++) nwin[i] = hist[i];
    nwin[7] = in_row;
  end

  for (genvar r = HR_LO; r <= HR_HI; r++) begin : g_hrow
    for (genvar c = 0; c < BLK_W; c++) begin : g_hcol
      logic [8*SX_W-1:0] x;
      for (genvar t = 0; t < 8; t++) begin : g_tap
        assign x[t*SX_W +: SX_W] = {1'b0, nwin[r][(c+t)*DATA_WIDTH +: DATA_WIDTH]};
      end
      fme_filter8 #(.IN_W(SX_W), .OUT_W(H_SUM_W)) u_filt (.x(x), .sum(hs[r][c]));
    end
  end

  for (genvar c = 0; c < BLK_W; c++) begin : g_vcol
    logic [8*SX_W-1:0] x;
    for (genvar t = 0; t < 8; t++) begin : g_tap
      assign x[t*SX_W +: SX_W] = {1'b0, nwin[t][(c+3)*DATA_WIDTH +: DATA_WIDTH]};
    end
    fme_filter8 #(.IN_W(SX_W), .OUT_W(H_SUM_W)) u_filt (.x(x), .sum(vs[c]));
    assign h_res[c*DATA_WIDTH +: DATA_WIDTH] = round_clip(32'(hs[3][c]), 6, RND6);
    assign v_res[c*DATA_WIDTH +: DATA_WIDTH] = round_clip(32'(vs[c]), 6, RND6);
  end

`ifdef FME_DIAG_EN
  logic [OUT_W-1:0] d_res;

  for (genvar c = 0; c < BLK_W; c++) begin : g_dcol
    logic [8*H_SUM_W-1:0]      x;
    logic signed [D_SUM_W-1:0] ds;
    for (genvar t = 0; t < 8; t++) begin : g_tap
      assign x[t*H_SUM_W +: H_SUM_W] = hs[t][c];
    end
    fme_filter8 #(.IN_W(H_SUM_W), .OUT_W(D_SUM_W)) u_filt (.x(x), .sum(ds));
    assign d_res[c*DATA_WIDTH +: DATA_WIDTH] = round_clip(32'(ds), 12, RND12);
  end

  always_ff @(posedge clock) begin
    if (reset) out_d <= '0;
    else if (emit) out_d <= d_res;
  end
`else
  assign out_d = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      rows_cnt  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      done      <= 1'b0;
      out_h     <= '0;
      out_v     <= '0;
      for (int i = 0; i < 7; i++) hist[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            rows_cnt <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            for (int i = 0; i < 7; i++) hist[i] <= nwin[i+1];
            rows_cnt <= rows_cnt + 1'b1;
            if (emit) begin
              out_valid <= 1'b1;
              out_row   <= IDX_W'(rows_cnt - CNT_W'(7));
              out_h     <= h_res;
              out_v     <= v_res;
            end
            if (rows_cnt == CNT_W'(BLK_H+6)) begin
              state    <= DONE;
              in_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
